byte_word_mem: RTL



---
 rtl/byte_word_mem.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/byte_word_mem.sv
// Byte-addressed node-state memory: big-endian word access with per-byte enables,
// registered responses, range checking and a run-time region-clear engine.
//
// state | meaning
// IDLE  | requests accepted; waiting for a clear start
// CLEAR | zeroing one byte per cycle from ptr up to end; requests held off
module byte_word_mem #(
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = 16,
  parameter int WORD_BYTES = 2,
  parameter int DATA_W     = 8 * WORD_BYTES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [WORD_BYTES-1:0] req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  input  logic                  clr_start,
  input  logic [ADDR_W-1:0]     clr_base,
  input  logic [ADDR_W-1:0]     clr_len,
  output logic                  busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SUM_W = ADDR_W + 1;
  localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(DEPTH);
  localparam logic [SUM_W-1:0] WB_S    = SUM_W'(WORD_BYTES);
  localparam logic [SUM_W-1:0] ONE_S   = SUM_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  clr_state_t state_q, state_d;
  logic [SUM_W-1:0] ptr_q, ptr_d;
  logic [SUM_W-1:0] end_q, end_d;

  logic [7:0] mem [DEPTH];

  logic              req_fire;
  logic              req_in_range;
  logic              wr_fire;
  logic              rd_fire;
  logic              clr_we;
  logic              clr_accept;
  logic [SUM_W-1:0]  req_end;
  logic [SUM_W-1:0]  clr_sum;
  logic [SUM_W-1:0]  clr_end_clip;
  logic [SUM_W-1:0]  ptr_inc;
  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  clr_idx;
  logic [DATA_W-1:0] rd_word;

  assign busy      = (state_q == CLEAR);
  assign req_ready = !busy && !reset;
  assign req_fire  = req_valid && req_ready;

  // Sums carry one extra bit so an address near the top of the space cannot wrap into range.
  assign req_end      = {1'b0, req_addr} + WB_S;
  assign req_in_range = (req_end <= DEPTH_S);
  assign wr_fire      = req_fire && req_wr && req_in_range;
  assign rd_fire      = req_fire && !req_wr && req_in_range;
  assign req_idx      = req_addr[IDX_W-1:0];

  assign clr_sum      = {1'b0, clr_base} + {1'b0, clr_len};
  assign clr_end_clip = (clr_sum > DEPTH_S) ? DEPTH_S : clr_sum;
  assign clr_accept   = clr_start && (clr_len != '0) && ({1'b0, clr_base} < DEPTH_S);
  assign ptr_inc      = ptr_q + ONE_S;
  assign clr_idx      = ptr_q[IDX_W-1:0];
  assign clr_we       = busy && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      end_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      end_q   <= end_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    end_d   = end_q;
    case (state_q)
      IDLE: begin
        if (clr_accept) begin
          state_d = CLEAR;
          ptr_d   = {1'b0, clr_base};
          end_d   = clr_end_clip;
        end
      end
      CLEAR: begin
        ptr_d = ptr_inc;
        if (ptr_inc == end_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Contents are deliberately not reset; reset only blocks further writes.
  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem[clr_idx] <= 8'h00;
    end else if (wr_fire) begin
      for (int k = 0; k < WORD_BYTES; k++) begin
        if (req_be[WORD_BYTES-1-k]) begin
          mem[req_idx + IDX_W'(k)] <= req_wdata[DATA_W-1-8*k -: 8];
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      rd_word[DATA_W-1-8*k -: 8] = mem[req_idx + IDX_W'(k)];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= req_fire;
      rsp_err   <= req_fire && !req_in_range;
      rsp_rdata <= rd_fire ? rd_word : '0;
    end
  end

endmodule
